// File: rtl/muldiv_unit.sv
// Iterative multiply (radix-4 Booth) / divide (restoring) unit with a DONE handshake.
// Define MULDIV_UNIT_DIV_EN to build the divider; without it divide requests are ignored.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int N  = WIDTH + 2;
  localparam int AW = N + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(N / 2);

`ifdef MULDIV_UNIT_DIV_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [N-1:0]     a_reg;
  logic [AW-1:0]    acc_reg;
  logic [N-1:0]     q_reg;
  logic             qm1_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [N-1:0]     a_ext;
  logic [N-1:0]     b_ext;
  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    booth_add;
  logic [AW-1:0]    booth_sum;

  // Two extra bits keep unsigned operands positive so one signed datapath serves both.
  always_comb begin
    a_ext = op[0] ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
    b_ext = op[0] ? {2'b00, b} : {{2{b[WIDTH-1]}}, b};
  end

  always_comb begin
    m_ext     = {{2{a_reg[N-1]}}, a_reg};
    booth_add = '0;
    case ({q_reg[1:0], qm1_reg})
      3'b001, 3'b010: booth_add = m_ext;
      3'b011:         booth_add = m_ext << 1;
      3'b100:         booth_add = -(m_ext << 1);
      3'b101, 3'b110: booth_add = -m_ext;
      default:        booth_add = '0;
    endcase
    booth_sum = acc_reg + booth_add;
  end

`ifdef MULDIV_UNIT_DIV_EN
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  logic [N-1:0]     b_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic             dz_reg;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_neg    = a_reg[N-1];
    b_neg    = b_reg[N-1];
    a_mag    = a_neg ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
    b_mag    = b_neg ? -b_reg[WIDTH-1:0] : b_reg[WIDTH-1:0];
    div_zero = (b_reg == '0);
    shifted  = {rem_reg, quo_reg[WIDTH-1]};
    diff     = shifted - {2'b00, b_mag};
    q_fix    = (a_neg ^ b_neg) ? -quo_reg : quo_reg;
    r_fix    = a_neg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
  end

  assign dz = dz_reg;
`else
  assign dz = 1'b0;
`endif

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      qm1_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
`ifdef MULDIV_UNIT_DIV_EN
      b_reg     <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dz_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          if (start && !op[1]) begin
            state_reg <= MUL;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            a_reg     <= a_ext;
            acc_reg   <= '0;
            q_reg     <= b_ext;
            qm1_reg   <= 1'b0;
          end
`ifdef MULDIV_UNIT_DIV_EN
          else if (start) begin
            state_reg <= DIV;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            a_reg     <= a_ext;
            b_reg     <= b_ext;
          end
`endif
        end
        MUL: begin
          if (cnt_reg == MUL_LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            hi_reg    <= {acc_reg[WIDTH-3:0], q_reg[N-1:WIDTH]};
            lo_reg    <= q_reg[WIDTH-1:0];
`ifdef MULDIV_UNIT_DIV_EN
            dz_reg    <= 1'b0;
`endif
          end else begin
            acc_reg <= {{2{booth_sum[AW-1]}}, booth_sum[AW-1:2]};
            q_reg   <= {booth_sum[1:0], q_reg[N-1:2]};
            qm1_reg <= q_reg[1];
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef MULDIV_UNIT_DIV_EN
        DIV: begin
          // First DIV cycle loads the dividend magnitude; the next WIDTH cycles iterate.
          if (cnt_reg == '0) begin
            rem_reg <= '0;
            quo_reg <= a_mag;
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            if (!diff[WIDTH+1]) begin
              rem_reg <= diff[WIDTH:0];
              quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
              rem_reg <= shifted[WIDTH:0];
              quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
            end
            if (cnt_reg == DIV_LAST) begin
              state_reg <= FIX;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        FIX: begin
          state_reg <= DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          dz_reg    <= div_zero;
          lo_reg    <= div_zero ? '1 : q_fix;
          hi_reg    <= div_zero ? a_reg[WIDTH-1:0] : r_fix;
        end
`endif
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32): latency, results, back-to-back and reset.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int lat;
  int dcount;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int l);
    bit seen;
    seen = 1'b0;
    l = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        l = cyc - t0;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input int elat, input logic [WIDTH-1:0] ehi,
                        input logic [WIDTH-1:0] elo, input logic edz);
    int l;
    issue(o, x, y);
    chk({tag, "_busy"}, busy, 1);
    wait_done(l);
    chk({tag, "_lat"}, l, elat);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dz"}, dz, edz);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    $display("op=%0d a=%h b=%h -> lat=%0d hi=%h lo=%h dz=%0d", o, x, y, l, hi, lo, dz);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", dz, 0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult_neg1x2",  2'b00, 32'hFFFFFFFF, 32'h00000002, 18, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("multu_maxx2",  2'b01, 32'hFFFFFFFF, 32'h00000002, 18, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("mult_minxmin", 2'b00, 32'h80000000, 32'h80000000, 18, 32'h40000000, 32'h00000000, 1'b0);
    run_op("mult_m3x7",    2'b00, 32'hFFFFFFFD, 32'h00000007, 18, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu_maxsq",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 18, 32'hFFFFFFFE, 32'h00000001, 1'b0);

    // Start re-pulsed mid-multiply must be ignored
    issue(2'b00, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    start = 1'b1; a = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("repulse_busy", busy, 1);
    wait_done(lat);
    chk("repulse_lat", lat, 18);
    chk("repulse_lo", lo, 32'h0000000F);
    chk("repulse_hi", hi, 32'h00000000);
    $display("repulse mult 3*5 -> lat=%0d hi=%h lo=%h", lat, hi, lo);

    // Back-to-back start in the DONE cycle
    start = 1'b1; op = 2'b01; a = 32'h12345678; b = 32'h00000010;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    chk("b2b_busy", busy, 1);
    chk("b2b_nodone", done, 0);
    chk("b2b_hold_lo", lo, 32'h0000000F);
    wait_done(lat);
    chk("b2b_lat", lat, 18);
    chk("b2b_hi", hi, 32'h00000001);
    chk("b2b_lo", lo, 32'h23456780);
    @(negedge clk);
    chk("b2b_pulse", done, 0);
    $display("b2b multu 12345678*10 -> lat=%0d hi=%h lo=%h", lat, hi, lo);

`ifdef MULDIV_UNIT_DIV_EN
    run_op("div_m7by2",    2'b10, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_by0",     2'b11, 32'h00000064, 32'h00000000, 34, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    run_op("div_minbym1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_7bym2",    2'b10, 32'h00000007, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu_maxby16", 2'b11, 32'hFFFFFFFF, 32'h00000010, 34, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
    run_op("div_negby0",   2'b10, 32'hFFFFFFF9, 32'h00000000, 34, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_op("mult_dzclr",   2'b00, 32'd3, 32'd5, 18, 32'h00000000, 32'h0000000F, 1'b0);
`else
    issue(2'b10, 32'd100, 32'd7);
    chk("nodiv_busy", busy, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("nodiv_quiet", dcount, 0);
    chk("nodiv_hi", hi, 32'h00000001);
    chk("nodiv_lo", lo, 32'h23456780);
    chk("nodiv_dz", dz, 0);
    $display("div request without divider -> busy/done cycles=%0d hi=%h lo=%h", dcount, hi, lo);
`endif

    // Reset at cycle 10 of a multiply abandons it
    issue(2'b00, 32'd10, 32'd10);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("midrst_nodone", dcount, 0);
    chk("midrst_lo_hold", lo, 0);
    $display("reset mid-mult -> done pulses=%0d hi=%h lo=%h", dcount, hi, lo);

    // Reset dominates a start sampled at the same edge
    @(negedge clk);
    reset = 1'b0; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    chk("rstdom_busy", busy, 0);
    @(negedge clk);
    chk("rstdom_done", done, 0);
    $display("reset with start -> busy=%0d done=%0d", busy, done);

    run_op("mult_afterrst", 2'b00, 32'd6, 32'd7, 18, 32'h00000000, 32'h0000002A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; SHALL be even and at least 8.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on the clk rising edge; asserted when 0.
REQ-004 Port: start  input  1  request pulse; sampled only while the unit is accepting.
REQ-005 Port: op  input  2  operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 Port: a  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-007 Port: b  input  WIDTH  multiplier or divisor; sampled with start.
REQ-008 Port: busy  output  1  operation in progress.
REQ-009 Port: done  output  1  one-cycle pulse; hi, lo and dz are valid in that cycle.
REQ-010 Port: hi  output  WIDTH  product upper half, or remainder.
REQ-011 Port: lo  output  WIDTH  product lower half, or quotient.
REQ-012 Port: dz  output  1  divide-by-zero flag of the last completed operation.

Function
REQ-013 FSM states SHALL be IDLE, MUL, DIV, FIX and DONE.
REQ-014 The unit SHALL accept start in IDLE and in DONE; a, b and op SHALL be latched at that edge.
REQ-015 Operand latching: op 00/10 sign-extend a and b to WIDTH+2 bits; op 01/11 zero-extend them.
REQ-016 Start SHALL be ignored in MUL, DIV and FIX; the latched operands SHALL NOT change.
REQ-017 Transitions: IDLE/DONE --start&op[1]=0--> MUL; IDLE/DONE --start&op[1]=1--> DIV.
REQ-018 Transitions: MUL --last iteration--> DONE; DIV --last iteration--> FIX; FIX --> DONE.
REQ-019 Transitions: DONE --no start--> IDLE.
REQ-020 MUL: radix-4 Booth recoding; one 2-bit step per cycle; (WIDTH+2)/2 steps.
REQ-021 Multiply result SHALL be the full 2*WIDTH-bit product: hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-022 Multiply latency: done SHALL assert exactly WIDTH/2+2 cycles after the start edge (18 for WIDTH=32).
REQ-023 DIV: restoring division on operand magnitudes; one quotient bit per cycle; WIDTH cycles.
REQ-024 FIX: apply signs for op 10; quotient is truncated toward zero; remainder takes the sign of the dividend.
REQ-025 Divide latency: done SHALL assert exactly WIDTH+2 cycles after the start edge (34 for WIDTH=32).
REQ-026 Divide result: lo = quotient, hi = remainder.
REQ-027 Divisor zero: lo = all ones, hi = a, dz = 1; latency SHALL be unchanged.
REQ-028 Signed most-negative / -1: lo = most-negative value, hi = 0, dz = 0.
REQ-029 busy SHALL be 1 in MUL, DIV and FIX, and 0 in IDLE and DONE.
REQ-030 done SHALL be 1 only in DONE.
REQ-031 hi, lo and dz SHALL update only on entry to DONE and hold until the next DONE.
REQ-032 Start accepted in DONE: done SHALL still pulse for that cycle, and the next operation SHALL begin at the same edge (back-to-back).

Reset
REQ-033 While reset=0 at an edge: state IDLE, busy=0, done=0, hi=0, lo=0, dz=0, and all internal iteration registers cleared.
REQ-034 Reset mid-operation SHALL abandon the operation: no done pulse, and hi/lo SHALL NOT take partial results.
REQ-035 Reset SHALL dominate start sampled at the same edge.

Configuration
REQ-036 Macro MULDIV_UNIT_DIV_EN defined: DIV and FIX states and the divide datapath SHALL be present; behaviour as above.
REQ-037 Macro MULDIV_UNIT_DIV_EN undefined: DIV and FIX states and the divider SHALL be absent.
REQ-038 Macro MULDIV_UNIT_DIV_EN undefined: start with op[1]=1 SHALL be ignored (no busy, no done, outputs unchanged), and dz SHALL be tied to 0.

Verification
REQ-039 WIDTH=32, mult a=FFFFFFFF b=00000002 -> done at cycle 18, hi=FFFFFFFF, lo=FFFFFFFE.
REQ-040 multu a=FFFFFFFF b=00000002 -> done at cycle 18, hi=00000001, lo=FFFFFFFE; then mult a=80000000 b=80000000 -> hi=40000000, lo=00000000.
REQ-041 (DIV_EN) div a=FFFFFFF9 (-7) b=00000002 -> done at cycle 34, lo=FFFFFFFD, hi=FFFFFFFF, dz=0.
REQ-042 (DIV_EN) divu a=00000064 b=0 -> done at cycle 34, lo=FFFFFFFF, hi=00000064, dz=1; then div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
REQ-043 mult 3*5 with start re-pulsed at cycle 5 using a=7 -> single done at cycle 18 with lo=0000000F; then start in the DONE cycle -> next done 18 cycles later and no IDLE cycle in between.
REQ-044 reset=0 at cycle 10 of a mult -> no done, hi=lo=0; without MULDIV_UNIT_DIV_EN, start with op=10 -> busy and done stay 0.
